// File: rtl/mux_pkg.sv
// Shared constants for the stream multiplexer: arbitration modes and FSM encoding.
package mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first requester found searching ptr, ptr+1, ... mod N.
module rr_pick #(
    parameter  int N    = 4,
    localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with packet locking, explicit-select or
// round-robin arbitration, and a single registered output stage.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int N     = 4,
    parameter  int MODE  = 0,
    localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SELW-1:0]    sel,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [SELW-1:0]    out_chan
);

    state_t            state_reg, state_next;
    logic [SELW-1:0]   ptr_reg, ptr_next;
    logic [SELW-1:0]   cur_reg, cur_next;

    logic              out_valid_reg;
    logic [WIDTH-1:0]  out_data_reg;
    logic              out_last_reg;
    logic [SELW-1:0]   out_chan_reg;

    logic [WIDTH-1:0]  ch_data [N];
    logic [SELW-1:0]   rr_idx;
    logic              rr_any;
    logic [SELW-1:0]   gnt_idx;
    logic              gnt_any;
    logic              ld;
    logic              xfer;
    logic              gnt_last;

    // Output register can take a new beat when empty or draining this cycle.
    assign ld = !out_valid_reg || out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ch
            assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
            assign in_ready[gi] = ld && gnt_any && (gnt_idx == SELW'(gi));
        end

        if (MODE == MODE_RR) begin : g_rr
            rr_pick #(.N(N)) u_pick (
                .req     (in_valid),
                .ptr     (ptr_reg),
                .gnt_idx (rr_idx),
                .gnt_any (rr_any)
            );
        end else begin : g_no_rr
            // Pointer has no role in select mode; keep it referenced but never granting.
            assign rr_idx = ptr_reg;
            assign rr_any = 1'b0;
        end
    endgenerate

    // Grant: locked channel wins; otherwise sel (range-checked) or the round-robin pick.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        if (state_reg == ST_LOCK) begin
            gnt_any = 1'b1;
            gnt_idx = cur_reg;
        end else if (MODE == MODE_RR) begin
            gnt_any = rr_any;
            gnt_idx = rr_idx;
        end else if (int'(sel) < N) begin
            gnt_any = 1'b1;
            gnt_idx = sel;
        end
    end

    assign xfer     = ld && gnt_any && in_valid[gnt_idx];
    assign gnt_last = in_last[gnt_idx];

    // Packet lock FSM and round-robin pointer advance, both driven by transfers.
    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        ptr_next   = ptr_reg;
        if (xfer) begin
            if (state_reg == ST_ARB && !gnt_last) begin
                state_next = ST_LOCK;
                cur_next   = gnt_idx;
            end else if (state_reg == ST_LOCK && gnt_last) begin
                state_next = ST_ARB;
            end
            if (gnt_last && MODE == MODE_RR) begin
                ptr_next = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SELW'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_ARB;
            ptr_reg   <= '0;
            cur_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            cur_reg   <= cur_next;
        end
    end

    // Output stage: load on transfer, empty on idle load slot, hold under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
            out_chan_reg  <= '0;
        end else if (ld) begin
            out_valid_reg <= xfer;
            if (xfer) begin
                out_data_reg <= ch_data[gnt_idx];
                out_last_reg <= gnt_last;
                out_chan_reg <= gnt_idx;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;
    assign out_chan  = out_chan_reg;

endmodule
